door_sequencer: RTL

- Cycle-accurate controller for the car doors. It sequences open, dwell, close and reopen using internal counters.
- Drives the door motor commands and the 2-bit door state bus `estado` consumed by the rest of the elevator design.
- Sits between the car controller (open/close requests, motion status) and the door actuators/sensors.

---
 rtl/door_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/door_sequencer.sv
// Car door sequencer: open stroke, dwell, close stroke and reopen handling,
// timed by a single shared cycle counter.  Every output is registered and
// is computed from the next-state values so it lines up with `estado`.
module door_sequencer #(
   parameter int MOVE_CYCLES = 20,
   parameter int OPEN_CYCLES = 100,
   parameter int MAX_REOPEN  = 3,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       open_req,
   input  logic       close_req,
   input  logic       obstruct,
   input  logic       car_moving,
   output logic [1:0] estado,
   output logic       motor_open,
   output logic       motor_close,
   output logic       doors_closed,
   output logic       timeout,
   output logic       nudge,
   output logic       fault
);

   localparam int RW = $clog2(MAX_REOPEN + 1);
   localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYCLES - 1);
   localparam logic [RW-1:0]    REOPEN_MAX = RW'(MAX_REOPEN);

   typedef enum logic [1:0] {
      CLOSED  = 2'b00,
      OPEN    = 2'b01,
      OPENING = 2'b10,
      CLOSING = 2'b11
   } doorState_t;

   doorState_t     state;
   doorState_t     stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic [RW-1:0]    reopenCnt;
   logic [RW-1:0]    reopenNext;
   logic             reopenLimit;
   logic             faultNext;

   // Once the reopen limit is reached a cab button no longer reopens the doors.
   assign reopenLimit = (reopenCnt == REOPEN_MAX);

   // Next-state, counter and reopen-count decisions for the door sequence.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      reopenNext = reopenCnt;
      faultNext  = fault | (car_moving && (state != CLOSED));

      unique case (state)
         CLOSED: begin
            cntNext = '0;
            if (open_req && !car_moving) begin
               stateNext = OPENING;
            end
         end

         OPENING: begin
            if (cnt == MOVE_LAST) begin
               stateNext = OPEN;
               cntNext   = '0;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end

         OPEN: begin
            if (obstruct || open_req) begin
               cntNext = '0;
            end else if (close_req) begin
               stateNext = CLOSING;
               cntNext   = '0;
            end else if (cnt == OPEN_LAST) begin
               stateNext = CLOSING;
               cntNext   = '0;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end

         CLOSING: begin
            if (obstruct || (open_req && !reopenLimit)) begin
               stateNext = OPENING;
               cntNext   = '0;
               if (!reopenLimit) begin
                  reopenNext = reopenCnt + RW'(1);
               end
            end else if (cnt == MOVE_LAST) begin
               stateNext  = CLOSED;
               cntNext    = '0;
               reopenNext = '0;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end

         default: begin
            stateNext  = CLOSED;
            cntNext    = '0;
            reopenNext = '0;
         end
      endcase
   end

   // State, counter and registered outputs, all cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= CLOSED;
         cnt          <= '0;
         reopenCnt    <= '0;
         estado       <= 2'b00;
         motor_open   <= 1'b0;
         motor_close  <= 1'b0;
         doors_closed <= 1'b1;
         timeout      <= 1'b0;
         nudge        <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= stateNext;
         cnt          <= cntNext;
         reopenCnt    <= reopenNext;
         estado       <= stateNext;
         motor_open   <= (stateNext == OPENING);
         motor_close  <= (stateNext == CLOSING);
         doors_closed <= (stateNext == CLOSED);
         timeout      <= (stateNext == OPEN) && (cntNext == OPEN_LAST);
         nudge        <= (reopenNext == REOPEN_MAX);
         fault        <= faultNext;
      end
   end

endmodule
